mem_data_issue: RTL and testbench
=================================

MEM_DATA_ISSUE -- requirements
Module: mem_data_issue

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset; all state SHALL clear immediately on rst=1.
REQ-002 clk  in  1  pipeline clock, rising-edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 exe_valid_in  in  1 / mem_allowin_out  out  1  EXE->MEM handshake; a transfer occurs when both are 1 at a clock edge.
REQ-005 exe_PC_in  in  32 / exe_addr_in  in  32 / exe_wdata_in  in  32  instruction PC, byte address, store data.
REQ-006 exe_load_in, exe_store_in  in  1 each  access type; both 0 means no memory access.
REQ-007 exe_size_in  in  2  0=byte, 1=half, 2=word; 3 is not used.
REQ-008 exe_wnum_in  in  5 / exe_exception_in  in  1  destination register and upstream exception flag.
REQ-009 data_req, data_wr  out  1 / data_size  out  2 / data_addr  out  32 / data_wstrb  out  4 / data_wdata  out  32  data-SRAM request.
REQ-010 data_addr_ok, data_data_ok  in  1 / data_rdata  in  32  data-SRAM responses.
REQ-011 mem_valid_out  out  1 / wb_allowin_in  in  1  MEM->WB handshake.
REQ-012 mem_PC_out  out  32 / mem_dm_data_out  out  32 / mem_wnum_out  out  5 / mem_adrl_out  out  2 (addr[1:0]) / mem_exception_out  out  1 / mem_ExcCode_out  out  5  payload to WB.
REQ-013 wb_ClrStpJmp_in  in  1  flush from WB; kills the instruction held in this stage.

Function
REQ-014 States: EMPTY, REQ, WAIT, DONE, DRAIN.
REQ-015 mem_allowin_out SHALL be 1 in EMPTY and in DONE with wb_allowin_in=1, and 0 in every other case, including DRAIN.
REQ-016 On accept, the block SHALL latch all exe_* inputs, and the next state SHALL be chosen as follows:
- access with exception_in=0 and the address aligned -> REQ;
- no access, exception_in=1, or misaligned -> DONE.
REQ-017 Misaligned means half with addr[0]=1, or word with addr[1:0]!=0. A misaligned access SHALL set mem_exception_out=1 and mem_ExcCode_out=0x04 (load) or 0x05 (store); no bus request SHALL be issued.
REQ-018 Upstream exception: mem_exception_out=1 and mem_ExcCode_out=0. No bus request SHALL be issued, so no store escapes.
REQ-019 In REQ, data_req=1 and all data_* outputs SHALL remain stable until data_addr_ok=1; then the next state is WAIT.
REQ-020 data_wr=store; data_size=size; data_addr=latched address.
REQ-021 data_wstrb: byte -> 1<<addr[1:0]; half -> addr[1] ? 1100 : 0011; word -> 1111; a load SHALL drive 0000.
REQ-022 data_wdata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
REQ-023 In WAIT, on data_ok=1 the block SHALL capture data_rdata into mem_dm_data_out (loads only) and move to DONE; data_req=0.
REQ-024 mem_valid_out SHALL equal (state==DONE).
REQ-025 DONE with wb_allowin_in=1 SHALL leave DONE: to the next instruction's state if exe_valid_in=1, otherwise to EMPTY.
REQ-026 Flush in REQ without addr_ok SHALL go to EMPTY, dropping data_req in the next cycle.
REQ-027 Flush in REQ with addr_ok in the same cycle SHALL go to DRAIN.
REQ-028 Flush in WAIT SHALL go to DRAIN, or to EMPTY if data_ok is in the same cycle.
REQ-029 Flush in DONE SHALL go to EMPTY; no accept is allowed in that cycle.
REQ-030 DRAIN SHALL wait for data_ok, discard the data, then go to EMPTY; this guarantees one data_ok per addr_ok.
REQ-031 Minimum load latency: accept at edge 0, req in cycle 1, addr_ok in cycle 1, data_ok in cycle 2, mem_valid_out=1 in cycle 3.

Reset
REQ-032 While rst=1 the block SHALL force:
- state=EMPTY, data_req=0, mem_valid_out=0;
- all payload outputs 0, data_wstrb=0;
- mem_allowin_out=1 after rst deasserts.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; the bus is reset together with this block.

Verification
REQ-034 Word load, addr 0x1004, addr_ok immediate, data_ok next cycle with rdata 0xDEADBEEF -> mem_valid_out in cycle 3, mem_dm_data_out=0xDEADBEEF, mem_adrl_out=0.
REQ-035 Byte store, addr 0x2003, wdata 0x000000A5 -> data_wstrb=1000, data_wdata=0xA5A5A5A5, data_wr=1, data_size=0.
REQ-036 Half load, addr 0x3001 -> no data_req, next cycle mem_valid_out=1, exception=1, ExcCode=0x04.
REQ-037 Load in WAIT, flush, data_ok 3 cycles later -> mem_allowin_out=0 until data_ok, then EMPTY, and mem_valid_out never asserts.
REQ-038 DONE with wb_allowin_in=0 for 4 cycles while exe_valid_in=1 -> payload stable and mem_allowin_out=0; when wb_allowin_in rises, back-to-back handoff with no bubble.
REQ-039 Assert rst while in WAIT -> data_req=0, mem_valid_out=0, all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mem_data_issue.sv
// MEM stage data-SRAM issue: accepts one EXE instruction, issues its load/store on the
// data bus, collects the response and hands the result to WB.
//
// state | meaning
// ------+-----------------------------------------------------------------
// EMPTY | no instruction held; ready to accept
// REQ   | data_req asserted, waiting for data_addr_ok
// WAIT  | address accepted, waiting for data_data_ok
// DONE  | result valid toward WB
// DRAIN | flushed after addr_ok; swallowing the orphan data_ok
module mem_data_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_valid_in,
    output logic        mem_allowin_out,
    input  logic [31:0] exe_PC_in,
    input  logic [31:0] exe_addr_in,
    input  logic [31:0] exe_wdata_in,
    input  logic        exe_load_in,
    input  logic        exe_store_in,
    input  logic [1:0]  exe_size_in,
    input  logic [4:0]  exe_wnum_in,
    input  logic        exe_exception_in,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        mem_valid_out,
    input  logic        wb_allowin_in,
    output logic [31:0] mem_PC_out,
    output logic [31:0] mem_dm_data_out,
    output logic [4:0]  mem_wnum_out,
    output logic [1:0]  mem_adrl_out,
    output logic        mem_exception_out,
    output logic [4:0]  mem_ExcCode_out,
    input  logic        wb_ClrStpJmp_in
);

    typedef enum logic [2:0] {
        S_EMPTY = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] pc_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        load_r;
    logic        store_r;
    logic [1:0]  size_r;
    logic [4:0]  wnum_r;
    logic        exc_r;
    logic [4:0]  code_r;
    logic [31:0] dm_data_r;

    logic        flush;
    logic        accept;
    logic        exe_access;
    logic        exe_misalign;
    logic        exe_exc;
    logic [4:0]  exe_code;
    state_t      accept_state;

    assign flush = wb_ClrStpJmp_in;

    // A flush in DONE kills the held instruction, so nothing may enter behind it that cycle.
    assign mem_allowin_out = (state == S_EMPTY) ||
                             (state == S_DONE && wb_allowin_in && !flush);
    assign accept = exe_valid_in && mem_allowin_out;

    assign exe_access   = exe_load_in || exe_store_in;
    assign exe_misalign = (exe_size_in == 2'd1 && exe_addr_in[0]) ||
                          (exe_size_in == 2'd2 && exe_addr_in[1:0] != 2'b00);
    assign exe_exc      = exe_exception_in || (exe_access && exe_misalign);

    always_comb begin
        exe_code = 5'h00;
        if (!exe_exception_in && exe_access && exe_misalign)
            exe_code = exe_load_in ? 5'h04 : 5'h05;
    end

    assign accept_state = (exe_access && !exe_exc) ? S_REQ : S_DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            pc_r      <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            load_r    <= 1'b0;
            store_r   <= 1'b0;
            size_r    <= '0;
            wnum_r    <= '0;
            exc_r     <= 1'b0;
            code_r    <= '0;
            dm_data_r <= '0;
        end else begin
            if (accept) begin
                pc_r    <= exe_PC_in;
                addr_r  <= exe_addr_in;
                wdata_r <= exe_wdata_in;
                load_r  <= exe_load_in;
                store_r <= exe_store_in;
                size_r  <= exe_size_in;
                wnum_r  <= exe_wnum_in;
                exc_r   <= exe_exc;
                code_r  <= exe_code;
            end
            case (state)
                S_EMPTY: begin
                    if (accept)
                        state <= accept_state;
                end
                S_REQ: begin
                    if (flush)
                        state <= data_addr_ok ? S_DRAIN : S_EMPTY;
                    else if (data_addr_ok)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        if (flush) begin
                            state <= S_EMPTY;
                        end else begin
                            if (load_r)
                                dm_data_r <= data_rdata;
                            state <= S_DONE;
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (flush)
                        state <= S_EMPTY;
                    else if (wb_allowin_in)
                        state <= accept ? accept_state : S_EMPTY;
                end
                S_DRAIN: begin
                    if (data_data_ok)
                        state <= S_EMPTY;
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    // Lane replication and strobes follow from the latched access, so reset zeroes them too.
    always_comb begin
        data_wstrb = 4'b0000;
        data_wdata = wdata_r;
        case (size_r)
            2'd0: begin
                data_wdata = {4{wdata_r[7:0]}};
                if (store_r)
                    data_wstrb = 4'b0001 << addr_r[1:0];
            end
            2'd1: begin
                data_wdata = {2{wdata_r[15:0]}};
                if (store_r)
                    data_wstrb = addr_r[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                if (store_r)
                    data_wstrb = 4'b1111;
            end
            default: begin
                data_wstrb = 4'b0000;
            end
        endcase
    end

    assign data_req          = (state == S_REQ);
    assign data_wr           = store_r;
    assign data_size         = size_r;
    assign data_addr         = addr_r;
    assign mem_valid_out     = (state == S_DONE);
    assign mem_PC_out        = pc_r;
    assign mem_dm_data_out   = dm_data_r;
    assign mem_wnum_out      = wnum_r;
    assign mem_adrl_out      = addr_r[1:0];
    assign mem_exception_out = exc_r;
    assign mem_ExcCode_out   = code_r;

endmodule

// File: tb/tb_mem_data_issue.sv
// Directed bench for mem_data_issue: table of single-instruction vectors plus
// hand-written sequences for flush, backpressure and mid-transaction reset.
module tb_mem_data_issue;

    logic        clk;
    logic        rst;
    logic        exe_valid_in;
    logic        mem_allowin_out;
    logic [31:0] exe_PC_in;
    logic [31:0] exe_addr_in;
    logic [31:0] exe_wdata_in;
    logic        exe_load_in;
    logic        exe_store_in;
    logic [1:0]  exe_size_in;
    logic [4:0]  exe_wnum_in;
    logic        exe_exception_in;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_valid_out;
    logic        wb_allowin_in;
    logic [31:0] mem_PC_out;
    logic [31:0] mem_dm_data_out;
    logic [4:0]  mem_wnum_out;
    logic [1:0]  mem_adrl_out;
    logic        mem_exception_out;
    logic [4:0]  mem_ExcCode_out;
    logic        wb_ClrStpJmp_in;

    mem_data_issue dut (
        .clk               (clk),
        .rst               (rst),
        .exe_valid_in      (exe_valid_in),
        .mem_allowin_out   (mem_allowin_out),
        .exe_PC_in         (exe_PC_in),
        .exe_addr_in       (exe_addr_in),
        .exe_wdata_in      (exe_wdata_in),
        .exe_load_in       (exe_load_in),
        .exe_store_in      (exe_store_in),
        .exe_size_in       (exe_size_in),
        .exe_wnum_in       (exe_wnum_in),
        .exe_exception_in  (exe_exception_in),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wstrb        (data_wstrb),
        .data_wdata        (data_wdata),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata),
        .mem_valid_out     (mem_valid_out),
        .wb_allowin_in     (wb_allowin_in),
        .mem_PC_out        (mem_PC_out),
        .mem_dm_data_out   (mem_dm_data_out),
        .mem_wnum_out      (mem_wnum_out),
        .mem_adrl_out      (mem_adrl_out),
        .mem_exception_out (mem_exception_out),
        .mem_ExcCode_out   (mem_ExcCode_out),
        .wb_ClrStpJmp_in   (wb_ClrStpJmp_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic        store;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exc;
        logic        exp_req;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic        exp_excp;
        logic [4:0]  exp_code;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_exe(input logic ld, input logic st, input logic [1:0] sz,
                             input logic [31:0] ad, input logic [31:0] wd, input logic ex,
                             input logic [31:0] pc, input logic [4:0] wn);
        exe_valid_in     = 1'b1;
        exe_load_in      = ld;
        exe_store_in     = st;
        exe_size_in      = sz;
        exe_addr_in      = ad;
        exe_wdata_in     = wd;
        exe_exception_in = ex;
        exe_PC_in        = pc;
        exe_wnum_in      = wn;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_1004, 32'h1234_5678, 1'b0, 1'b1, 4'b0000, 32'h1234_5678, 1'b0, 5'h00};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 32'h0000_2003, 32'h0000_00A5, 1'b0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b0, 5'h00};
        vecs[2]  = '{1'b1, 1'b0, 2'd1, 32'h0000_3001, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 5'h04};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 32'h0000_2002, 32'h1234_BEEF, 1'b0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 5'h00};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 32'h0000_2000, 32'h0000_5A5A, 1'b0, 1'b1, 4'b0011, 32'h5A5A_5A5A, 1'b0, 5'h00};
        vecs[5]  = '{1'b0, 1'b1, 2'd2, 32'h0000_2008, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 5'h00};
        vecs[6]  = '{1'b0, 1'b1, 2'd2, 32'h0000_200A, 32'h1111_1111, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 5'h05};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 32'h0000_4000, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 5'h00};
        vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h0000_4002, 32'h0000_0000, 1'b0, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 5'h00};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 32'h0000_2001, 32'h0000_0077, 1'b0, 1'b1, 4'b0010, 32'h7777_7777, 1'b0, 5'h00};
        vecs[10] = '{1'b1, 1'b0, 2'd0, 32'h0000_3003, 32'h0000_0011, 1'b0, 1'b1, 4'b0000, 32'h1111_1111, 1'b0, 5'h00};
        vecs[11] = '{1'b0, 1'b1, 2'd2, 32'h0000_5001, 32'h0000_0000, 1'b1, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 5'h00};

        rst = 1'b1;
        exe_valid_in = 1'b0;
        exe_PC_in = '0; exe_addr_in = '0; exe_wdata_in = '0;
        exe_load_in = 1'b0; exe_store_in = 1'b0; exe_size_in = '0;
        exe_wnum_in = '0; exe_exception_in = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        wb_allowin_in = 1'b1; wb_ClrStpJmp_in = 1'b0;

        #12;
        chk("rst data_req", {31'b0, data_req}, 32'd0);
        chk("rst valid", {31'b0, mem_valid_out}, 32'd0);
        chk("rst wstrb", {28'b0, data_wstrb}, 32'd0);
        chk("rst pc", mem_PC_out, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst allowin", {31'b0, mem_allowin_out}, 32'd1);
        tick();

        for (int i = 0; i < NVEC; i++) begin
            drive_exe(vecs[i].load, vecs[i].store, vecs[i].size, vecs[i].addr,
                      vecs[i].wdata, vecs[i].exc, 32'h100 + i, 5'(i + 1));
            #1;
            chk($sformatf("v%0d allowin", i), {31'b0, mem_allowin_out}, 32'd1);
            tick();
            exe_valid_in = 1'b0;
            #1;
            chk($sformatf("v%0d data_req", i), {31'b0, data_req}, {31'b0, vecs[i].exp_req});
            if (vecs[i].exp_req) begin
                chk($sformatf("v%0d valid_in_req", i), {31'b0, mem_valid_out}, 32'd0);
                chk($sformatf("v%0d wstrb", i), {28'b0, data_wstrb}, {28'b0, vecs[i].exp_wstrb});
                chk($sformatf("v%0d wdata", i), data_wdata, vecs[i].exp_wdata);
                chk($sformatf("v%0d wr", i), {31'b0, data_wr}, {31'b0, vecs[i].store});
                chk($sformatf("v%0d size", i), {30'b0, data_size}, {30'b0, vecs[i].size});
                chk($sformatf("v%0d addr", i), data_addr, vecs[i].addr);
                data_addr_ok = 1'b1;
                tick();
                data_addr_ok = 1'b0;
                data_data_ok = 1'b1;
                data_rdata = 32'hC0DE_0000 + i;
                if (i == 0) data_rdata = 32'hDEAD_BEEF;
                #1;
                chk($sformatf("v%0d valid_in_wait", i), {31'b0, mem_valid_out}, 32'd0);
                tick();
                data_data_ok = 1'b0;
                if (vecs[i].load)
                    chk($sformatf("v%0d dm_data", i), mem_dm_data_out,
                        (i == 0) ? 32'hDEAD_BEEF : 32'hC0DE_0000 + i);
            end
            chk($sformatf("v%0d valid", i), {31'b0, mem_valid_out}, 32'd1);
            chk($sformatf("v%0d exception", i), {31'b0, mem_exception_out}, {31'b0, vecs[i].exp_excp});
            chk($sformatf("v%0d exccode", i), {27'b0, mem_ExcCode_out}, {27'b0, vecs[i].exp_code});
            chk($sformatf("v%0d adrl", i), {30'b0, mem_adrl_out}, {30'b0, vecs[i].addr[1:0]});
            chk($sformatf("v%0d pc", i), mem_PC_out, 32'h100 + i);
            tick();
            chk($sformatf("v%0d empty_after", i), {31'b0, mem_valid_out}, 32'd0);
        end

        // data_* must hold while addr_ok is withheld
        drive_exe(1'b0, 1'b1, 2'd0, 32'h0000_7002, 32'h0000_003C, 1'b0, 32'h70, 5'd2);
        tick();
        exe_valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("hold req", {31'b0, data_req}, 32'd1);
            chk("hold addr", data_addr, 32'h0000_7002);
            chk("hold wstrb", {28'b0, data_wstrb}, 32'b0100);
            chk("hold wdata", data_wdata, 32'h3C3C_3C3C);
            tick();
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("hold done valid", {31'b0, mem_valid_out}, 32'd1);
        tick();

        // flush in WAIT, data_ok three cycles later
        drive_exe(1'b1, 1'b0, 2'd2, 32'h0000_6000, 32'h0, 1'b0, 32'h60, 5'd4);
        tick();
        exe_valid_in = 1'b0;
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        wb_ClrStpJmp_in = 1'b1;
        tick();
        wb_ClrStpJmp_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) data_data_ok = 1'b1;
            #1;
            chk("drain allowin", {31'b0, mem_allowin_out}, 32'd0);
            chk("drain valid", {31'b0, mem_valid_out}, 32'd0);
            chk("drain req", {31'b0, data_req}, 32'd0);
            tick();
        end
        data_data_ok = 1'b0;
        chk("drain exit allowin", {31'b0, mem_allowin_out}, 32'd1);
        chk("drain exit valid", {31'b0, mem_valid_out}, 32'd0);

        // flush in REQ without addr_ok
        drive_exe(1'b1, 1'b0, 2'd2, 32'h0000_6100, 32'h0, 1'b0, 32'h61, 5'd5);
        tick();
        exe_valid_in = 1'b0;
        wb_ClrStpJmp_in = 1'b1;
        tick();
        wb_ClrStpJmp_in = 1'b0;
        chk("flush req data_req", {31'b0, data_req}, 32'd0);
        chk("flush req allowin", {31'b0, mem_allowin_out}, 32'd1);

        // flush in REQ together with addr_ok goes to DRAIN
        drive_exe(1'b1, 1'b0, 2'd2, 32'h0000_6200, 32'h0, 1'b0, 32'h62, 5'd6);
        tick();
        exe_valid_in = 1'b0;
        wb_ClrStpJmp_in = 1'b1;
        data_addr_ok = 1'b1;
        tick();
        wb_ClrStpJmp_in = 1'b0;
        data_addr_ok = 1'b0;
        chk("flush addrok allowin", {31'b0, mem_allowin_out}, 32'd0);
        chk("flush addrok req", {31'b0, data_req}, 32'd0);
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        chk("flush addrok exit", {31'b0, mem_allowin_out}, 32'd1);
        chk("flush addrok valid", {31'b0, mem_valid_out}, 32'd0);

        // flush in WAIT with data_ok in the same cycle
        drive_exe(1'b1, 1'b0, 2'd2, 32'h0000_6300, 32'h0, 1'b0, 32'h63, 5'd7);
        tick();
        exe_valid_in = 1'b0;
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        wb_ClrStpJmp_in = 1'b1;
        data_data_ok = 1'b1;
        tick();
        wb_ClrStpJmp_in = 1'b0;
        data_data_ok = 1'b0;
        chk("flush dataok allowin", {31'b0, mem_allowin_out}, 32'd1);
        chk("flush dataok valid", {31'b0, mem_valid_out}, 32'd0);

        // WB backpressure for 4 cycles, then back-to-back handoff
        drive_exe(1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 32'hA0, 5'd3);
        tick();
        wb_allowin_in = 1'b0;
        drive_exe(1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 32'hB0, 5'd7);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("bp valid", {31'b0, mem_valid_out}, 32'd1);
            chk("bp pc", mem_PC_out, 32'hA0);
            chk("bp allowin", {31'b0, mem_allowin_out}, 32'd0);
            tick();
        end
        wb_allowin_in = 1'b1;
        #1;
        chk("bp release allowin", {31'b0, mem_allowin_out}, 32'd1);
        tick();
        exe_valid_in = 1'b0;
        chk("bp next valid", {31'b0, mem_valid_out}, 32'd1);
        chk("bp next pc", mem_PC_out, 32'hB0);
        chk("bp next wnum", {27'b0, mem_wnum_out}, 32'd7);
        tick();
        chk("bp empty", {31'b0, mem_valid_out}, 32'd0);

        // asynchronous reset while in WAIT
        drive_exe(1'b1, 1'b0, 2'd2, 32'h0000_8004, 32'h0, 1'b0, 32'h80, 5'd9);
        tick();
        exe_valid_in = 1'b0;
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        chk("pre-rst addr", data_addr, 32'h0000_8004);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst req", {31'b0, data_req}, 32'd0);
        chk("async rst valid", {31'b0, mem_valid_out}, 32'd0);
        chk("async rst addr", data_addr, 32'd0);
        chk("async rst pc", mem_PC_out, 32'd0);
        chk("async rst wnum", {27'b0, mem_wnum_out}, 32'd0);
        chk("async rst size", {30'b0, data_size}, 32'd0);
        #1;
        rst = 1'b0;
        #1;
        chk("post-rst allowin", {31'b0, mem_allowin_out}, 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
